hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Generalised interlock for the 5-stage core: per-register countdown scoreboard covers loads
//  and multi-cycle mul/div with configurable result latency. Stalls IF/ID and injects an
//  ID/EX bubble on RaW (and WaW-overtake) hazards. Handles EX redirect flushes and external
//  memory wait. Counts stall cycles. Sits beside the ID stage; forwarding unit unchanged.
// PARAMETERS
//  REG_AW      5   register index width (2**REG_AW architectural regs, x0 hardwired zero)
//  LOAD_LAT    1   cycles after load leaves ID before its result is forwardable
//  MULDIV_LAT  4   same, for mul/div ops (must be >= LOAD_LAT)
//  CNT_W       $clog2(MULDIV_LAT+1)  countdown width
//  PERF_W      32  stall performance counter width
// PORTS
//  clk            in   1       core clock
//  rst_n          in   1       synchronous reset, active-low
//  id_valid       in   1       ID holds a valid instruction
//  id_rs1,id_rs2  in   REG_AW  ID source indices
//  id_rs1_used    in   1       rs1 actually read (qualifies hazard check)
//  id_rs2_used    in   1       rs2 actually read
//  id_rd          in   REG_AW  ID destination index
//  id_rd_wr       in   1       ID instruction writes rd
//  id_is_load     in   1       ID instruction is a load
//  id_is_muldiv   in   1       ID instruction is mul/div
//  ex_redirect    in   1       taken branch/jump resolved in EX this cycle
//  mem_stall      in   1       data memory not ready; whole pipe frozen
//  pc_en          out  1       PC update enable
//  if_id_en       out  1       IF/ID register update enable
//  id_ex_bubble   out  1       force NOP control into ID/EX
//  if_id_flush    out  1       clear IF/ID to NOP
//  stall_cycles   out  PERF_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Scoreboard: cnt[r] per reg, CNT_W bits; cnt[0] permanently 0. cnt!=0 => result pending.
//  - hz_raw = id_valid & ((id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0) | (same for rs2)).
//  - new_lat = id_is_muldiv ? MULDIV_LAT : id_is_load ? LOAD_LAT : 0.
//  - hz_waw = id_valid & id_rd_wr & id_rd!=0 & cnt[id_rd] > new_lat.
//  - hazard = hz_raw | hz_waw. Combinational outputs, priority high->low:
//    1 mem_stall: pc_en=0 if_id_en=0 bubble=0 flush=0; cnt frozen (no decrement, no set).
//    2 ex_redirect: pc_en=1 if_id_en=1 flush=1 bubble=1; ID instr squashed, no cnt set.
//    3 hazard: pc_en=0 if_id_en=0 bubble=1 flush=0.
//    4 else: pc_en=1 if_id_en=1 bubble=0 flush=0.
//  - Issue = case 4 & id_valid: if id_rd_wr & id_rd!=0 & new_lat!=0, cnt[id_rd]<=new_lat.
//  - Every non-mem_stall cycle all other nonzero cnt decrement by 1; set overrides decrement
//    of same reg. Zero never underflows.
//  - LOAD_LAT=1: load-use gives exactly 1 stall cycle (classic). MULDIV_LAT=4: 4 cycles.
//  - stall_cycles +1 each clock hazard (case 3) is asserted; saturates at all-ones.
//  - Reset (rst_n=0 at clk edge): all cnt<=0, stall_cycles<=0. While rst_n low outputs forced
//    pc_en=0 if_id_en=0 bubble=1 flush=0. Reset mid-stall drops all pending entries.
//  - Redirect during outstanding mul/div: cnt entries kept (instruction already past ID).
// STRUCTURE
//  - Shared package: latency constants, REG_AW default, new_lat encode function.
//  - Sub-module hazard_scoreboard: cnt array, set/decrement/freeze, two read ports + rd read.
//  - Top: hazard/priority logic and perf counter.
// TESTING
//  - load x5; add x6,x5,x1 (rs1_used) -> one cycle pc_en=0,bubble=1; then issue; stall_cycles=1.
//  - same with rs1_used=0 (e.g. lui) -> no stall; rs=x0 after load to x0 -> no stall.
//  - mul x7; add x8,x7,x2 -> 4 stall cycles, issue on 5th; with mem_stall high 2 cycles
//    mid-stall -> total 6 cycles held, stall_cycles=4.
//  - mul x9 then immediate load x9 -> hz_waw stalls until cnt[x9]<=1, then load issues.
//  - load x5 + dependent in ID with ex_redirect=1 -> flush=1,bubble=1,pc_en=1; no stall next cycle.
//  - rst_n low during mul countdown -> cnt cleared; after release dependent issues with no stall.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and latency helpers for the ID-stage interlock.
// Default widths/latencies live here so the core and bench agree.
package hazard_stall_ctrl_pkg;

  localparam int REG_AW_DEF     = 5;
  localparam int LOAD_LAT_DEF   = 1;
  localparam int MULDIV_LAT_DEF = 4;
  localparam int PERF_W_DEF     = 32;

  // Which of the four priority cases applies this cycle.
  typedef enum logic [1:0] {
    CTL_RUN,
    CTL_HAZ,
    CTL_REDIR,
    CTL_FRZ
  } ctl_mode_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_bubble;
    logic if_id_flush;
  } pipe_ctl_t;

  // Cycles until the ID instruction's result becomes forwardable; 0 = ALU.
  function automatic int new_lat_enc(input logic is_load, input logic is_muldiv,
                                     input int load_lat, input int muldiv_lat);
    if (is_muldiv) return muldiv_lat;
    if (is_load)   return load_lat;
    return 0;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown of cycles until a pending result is forwardable.
// x0 is never written, so its entry stays at zero from reset onward.
module hazard_scoreboard
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic [CNT_W-1:0]  set_val,
  input  logic [REG_AW-1:0] rs1_idx,
  input  logic [REG_AW-1:0] rs2_idx,
  input  logic [REG_AW-1:0] rd_idx,
  output logic [CNT_W-1:0]  rs1_cnt,
  output logic [CNT_W-1:0]  rs2_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int NREGS = 1 << REG_AW;

  logic [NREGS-1:0][CNT_W-1:0] cnt;

  // A fresh issue replaces the decrement on the same entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!freeze) begin
      for (int r = 1; r < NREGS; r++) begin
        if (set_en && set_idx == REG_AW'(r))
          cnt[r] <= set_val;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  assign rs1_cnt = cnt[rs1_idx];
  assign rs2_cnt = cnt[rs2_idx];
  assign rd_cnt  = cnt[rd_idx];

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage interlock: RaW/WaW stalls against the countdown scoreboard,
// redirect flush, memory freeze and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int LOAD_LAT   = LOAD_LAT_DEF,
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = $clog2(MULDIV_LAT + 1),
  parameter int PERF_W     = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_wr,
  input  logic              id_is_load,
  input  logic              id_is_muldiv,
  input  logic              ex_redirect,
  input  logic              mem_stall,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [PERF_W-1:0] stall_cycles
);

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, new_lat;
  logic             hz_raw, hz_waw, hazard, set_en;
  ctl_mode_e        mode;
  pipe_ctl_t        ctl;

  assign new_lat = CNT_W'(new_lat_enc(id_is_load, id_is_muldiv, LOAD_LAT, MULDIV_LAT));

  assign hz_raw = id_valid &
                  ((id_rs1_used & (id_rs1 != '0) & (rs1_cnt != '0)) |
                   (id_rs2_used & (id_rs2 != '0) & (rs2_cnt != '0)));
  // A shorter-latency write must not land before an older, slower one.
  assign hz_waw = id_valid & id_rd_wr & (id_rd != '0) & (rd_cnt > new_lat);
  assign hazard = hz_raw | hz_waw;

  always_comb begin
    mode = CTL_RUN;
    if (mem_stall)        mode = CTL_FRZ;
    else if (ex_redirect) mode = CTL_REDIR;
    else if (hazard)      mode = CTL_HAZ;
  end

  always_comb begin
    ctl = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_bubble: 1'b0, if_id_flush: 1'b0};
    unique case (mode)
      CTL_FRZ:   ctl = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_bubble: 1'b0, if_id_flush: 1'b0};
      CTL_REDIR: ctl = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_bubble: 1'b1, if_id_flush: 1'b1};
      CTL_HAZ:   ctl = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_bubble: 1'b1, if_id_flush: 1'b0};
      default:   ;
    endcase
    // Hold the front end and keep ID/EX empty while in reset.
    if (!rst_n)
      ctl = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_bubble: 1'b1, if_id_flush: 1'b0};
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign if_id_flush  = ctl.if_id_flush;

  assign set_en = (mode == CTL_RUN) & id_valid & id_rd_wr & (id_rd != '0) & (new_lat != '0);

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .freeze  (mem_stall),
    .set_en  (set_en),
    .set_idx (id_rd),
    .set_val (new_lat),
    .rs1_idx (id_rs1),
    .rs2_idx (id_rs2),
    .rd_idx  (id_rd),
    .rs1_cnt (rs1_cnt),
    .rs2_cnt (rs2_cnt),
    .rd_cnt  (rd_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (mode == CTL_HAZ && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
